// File: rtl/ty_fifo_stream_buff_if.sv
// Valid/ready word stream between pipeline stages; master drives valid/data, slave drives ready.
// No storage: a pure bundle of wires, so it adds no latency and has no backpressure of its own.
interface ty_fifo_stream_buff_if #(
    parameter int DBITS = 32
);
    logic             valid;
    logic             ready;
    logic [DBITS-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/ty_fifo_stream_buff.sv
// Stream FIFO: DEPTH words, with the head word held in a registered first-word-fall-through stage.
// A write lands on m_valid in 1 cycle; s_ready deasserts at count==DEPTH and comes from registered state only.
module ty_fifo_stream_buff #(
    parameter int ABITS    = 4,
    parameter int DBITS    = 32,
    parameter int AF_LEVEL = 2**ABITS-2,
    parameter int AE_LEVEL = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    ty_fifo_stream_buff_if.slave  s,
    ty_fifo_stream_buff_if.master m,
    output logic [ABITS:0]        count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  ovf_err,
    output logic                  udf_err
);
    localparam int DEPTH = 1 << ABITS;
    localparam logic [ABITS:0] DEPTH_C = (ABITS+1)'(DEPTH);
    localparam logic [ABITS:0] AF_C    = (ABITS+1)'(AF_LEVEL);
    localparam logic [ABITS:0] AE_C    = (ABITS+1)'(AE_LEVEL);

    logic [DBITS-1:0] mem [DEPTH];
    logic [ABITS-1:0] wptr, rptr;
    logic             s_ready_r, m_valid_r;
    logic [DBITS-1:0] m_data_r;

    logic             wr, rd, load_out, arr_empty, bypass, arr_wr;
    logic [ABITS:0]   arr_cnt, count_nxt;
    logic [ABITS+1:0] sum;

    assign s.ready = s_ready_r;
    assign m.valid = m_valid_r;
    assign m.data  = m_data_r;

    always_comb begin
        wr        = s.valid & s_ready_r & ~flush;
        rd        = m_valid_r & m.ready & ~flush;
        // The output register is part of count, so the array holds the rest.
        arr_cnt   = count - {{ABITS{1'b0}}, m_valid_r};
        arr_empty = (arr_cnt == '0);
        load_out  = ~m_valid_r | rd;
        bypass    = load_out & arr_empty & wr;
        arr_wr    = wr & ~bypass;
        sum       = {1'b0, count} + {{(ABITS+1){1'b0}}, wr} - {{(ABITS+1){1'b0}}, rd};
        count_nxt = flush ? '0 : sum[ABITS:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count        <= '0;
            s_ready_r    <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            ovf_err      <= 1'b0;
            udf_err      <= 1'b0;
            wptr         <= '0;
            rptr         <= '0;
            m_valid_r    <= 1'b0;
            m_data_r     <= '0;
        end else begin
            count        <= count_nxt;
            s_ready_r    <= (count_nxt < DEPTH_C);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            ovf_err      <= ovf_err | (flush & s.valid & s_ready_r);
            // A borrow out of the count arithmetic means the bookkeeping is broken.
            udf_err      <= udf_err | (~flush & sum[ABITS+1]);
            if (flush) begin
                wptr      <= '0;
                rptr      <= '0;
                m_valid_r <= 1'b0;
            end else begin
                if (arr_wr)
                    wptr <= wptr + 1'b1;
                if (load_out) begin
                    if (!arr_empty) begin
                        m_data_r  <= mem[rptr];
                        rptr      <= rptr + 1'b1;
                        m_valid_r <= 1'b1;
                    end else if (wr) begin
                        m_data_r  <= s.data;
                        m_valid_r <= 1'b1;
                    end else begin
                        m_valid_r <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (arr_wr)
            mem[wptr] <= s.data;
    end
endmodule

// File: tb/tb_ty_fifo_stream_buff.sv
// Directed and random stimulus against a queue model of the FIFO, checked every cycle.
module tb_ty_fifo_stream_buff;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  count;
    logic        almost_full, almost_empty, ovf_err, udf_err;

    ty_fifo_stream_buff_if #(.DBITS(32)) s_if ();
    ty_fifo_stream_buff_if #(.DBITS(32)) m_if ();

    ty_fifo_stream_buff #(.ABITS(4), .DBITS(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .s            (s_if),
        .m            (m_if),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the FIFO is just an ordered list of accepted words.
    logic [31:0] q[$];
    logic [31:0] mdl_last = '0;
    bit          mdl_ovf = 1'b0;
    int          mdl_acc = 0;
    bit          can_w, has_w;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            mdl_last = '0;
            mdl_ovf  = 1'b0;
        end else begin
            can_w = (q.size() < DEPTH);
            has_w = (q.size() > 0);
            if (flush) begin
                if (s_if.valid && can_w) mdl_ovf = 1'b1;
                q.delete();
            end else begin
                if (m_if.ready && has_w) void'(q.pop_front());
                if (s_if.valid && can_w) begin
                    q.push_back(s_if.data);
                    mdl_acc++;
                end
            end
            if (q.size() > 0) mdl_last = q[0];
        end
    end

    always @(negedge clock) begin
        check("s_ready",      s_if.ready,   q.size() < DEPTH);
        check("m_valid",      m_if.valid,   q.size() > 0);
        check("m_data",       m_if.data,    mdl_last);
        check("count",        count,        q.size());
        check("almost_full",  almost_full,  q.size() >= DEPTH-2);
        check("almost_empty", almost_empty, q.size() <= 2);
        check("ovf_err",      ovf_err,      mdl_ovf);
        check("udf_err",      udf_err,      1'b0);
    end

    task automatic cyc(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
        s_if.valid = sv;
        s_if.data  = sd;
        m_if.ready = mr;
        flush      = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, s_if.ready,   1'b1);
        check({tag, "_m_valid"}, m_if.valid,   1'b0);
        check({tag, "_m_data"},  m_if.data,    32'h0);
        check({tag, "_count"},   count,        5'd0);
        check({tag, "_af"},      almost_full,  1'b0);
        check({tag, "_ae"},      almost_empty, 1'b1);
        check({tag, "_ovf"},     ovf_err,      1'b0);
        check({tag, "_udf"},     udf_err,      1'b0);
    endtask

    initial begin
        int cycles;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        check_reset_vals("rst");

        // Single word into empty FIFO
        cyc(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
        check("w1_m_valid", m_if.valid,   1'b1);
        check("w1_m_data",  m_if.data,    32'hA5A5A5A5);
        check("w1_count",   count,        5'd1);
        check("w1_ae",      almost_empty, 1'b1);

        // Fill to full
        for (int i = 1; i < 16; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 12) check("fill13_af", almost_full, 1'b0);
            if (i == 13) check("fill14_af", almost_full, 1'b1);
        end
        check("full_count",   count,      5'd16);
        check("full_s_ready", s_if.ready, 1'b0);
        check("full_af",      almost_full, 1'b1);
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
        check("w17_count",    count,      5'd16);
        check("w17_m_data",   m_if.data,  32'hA5A5A5A5);

        // Streaming from full
        for (int k = 0; k < 100; k++) begin
            cyc(1'b1, 32'h100 + 32'(k), 1'b1, 1'b0);
            if (k == 0) begin
                check("pop1_s_ready", s_if.ready, 1'b1);
                check("pop1_count",   count,      5'd15);
                check("pop1_m_data",  m_if.data,  32'h1);
            end
        end
        check("stream_count", count, 5'd15);
        repeat (20) cyc(1'b0, '0, 1'b1, 1'b0);
        check("drain_count", count, 5'd0);

        // Bypass at count 1
        cyc(1'b1, 32'h10, 1'b0, 1'b0);
        check("c1_m_data", m_if.data, 32'h10);
        cyc(1'b1, 32'h11, 1'b1, 1'b0);
        check("byp_m_data",  m_if.data,  32'h11);
        check("byp_count",   count,      5'd1);
        check("byp_m_valid", m_if.valid, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("byp_empty", m_if.valid, 1'b0);

        // Random traffic
        mdl_acc = 0;
        cycles  = 0;
        while (mdl_acc < 10000 && cycles < 60000) begin
            cyc(1'($urandom % 2), $urandom, 1'($urandom % 2), 1'b0);
            cycles++;
        end
        check("rand_budget", mdl_acc >= 10000, 1'b1);
        check("rand_udf",    udf_err,          1'b0);
        repeat (20) cyc(1'b0, '0, 1'b1, 1'b0);

        // Flush with a write pending
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        check("f8_count", count, 5'd8);
        cyc(1'b1, 32'hBAD, 1'b0, 1'b1);
        check("flush_count",   count,      5'd0);
        check("flush_m_valid", m_if.valid, 1'b0);
        check("flush_s_ready", s_if.ready, 1'b1);
        check("flush_ovf",     ovf_err,    1'b1);
        check("flush_m_data",  m_if.data,  32'h200);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h300 + 32'(i), 1'(i % 2), 1'b0);
        s_if.valid = 1'b1;
        m_if.ready = 1'b1;
        #3 reset = 1'b1;
        #1;
        check_reset_vals("arst");
        @(posedge clock);
        #1;
        check_reset_vals("arst_edge");
        reset = 1'b0;
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
